// File: rtl/sc_pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding and default PC width.
// Pure declarations, so there is no latency or flow control here.
package sc_pc_sequencer_pkg;

   localparam int PCSEQ_DEFAULT_W = 11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_ADVANCE = 3'd2,
      ST_HALT    = 3'd3,
      ST_ERROR   = 3'd4
   } pcseq_state_t;

   function automatic logic is_running(input pcseq_state_t s);
      return (s == ST_FETCH) || (s == ST_ADVANCE);
   endfunction

endpackage

// File: rtl/sc_pc_sequencer_if.sv
// Control/fetch bundle between the control unit, instruction memory and the PC sequencer.
// Wires only; req/ack handshake timing is owned by the sequencer.
interface sc_pc_sequencer_if
   import sc_pc_sequencer_pkg::*;
#(
   parameter int W = PCSEQ_DEFAULT_W
);

   logic         PCSEQ_START;
   logic         PCSEQ_HALT;
   logic         PCSEQ_FETCH_ACK;
   logic         PCSEQ_BRANCH_VALID;
   logic [W-1:0] PCSEQ_BRANCH_TARGET;
   logic [W-1:0] PCSEQ_PC_OUTPUT;
   logic         PCSEQ_FETCH_REQ;
   logic         PCSEQ_RUNNING;
   logic         PCSEQ_WRAP;
   logic         PCSEQ_ERROR;

   modport master (
      output PCSEQ_START, PCSEQ_HALT, PCSEQ_FETCH_ACK,
             PCSEQ_BRANCH_VALID, PCSEQ_BRANCH_TARGET,
      input  PCSEQ_PC_OUTPUT, PCSEQ_FETCH_REQ, PCSEQ_RUNNING,
             PCSEQ_WRAP, PCSEQ_ERROR
   );

   modport slave (
      input  PCSEQ_START, PCSEQ_HALT, PCSEQ_FETCH_ACK,
             PCSEQ_BRANCH_VALID, PCSEQ_BRANCH_TARGET,
      output PCSEQ_PC_OUTPUT, PCSEQ_FETCH_REQ, PCSEQ_RUNNING,
             PCSEQ_WRAP, PCSEQ_ERROR
   );

endinterface

// File: rtl/sc_pc_next.sv
// Next-PC selection: branch target or PC+1 modulo 2^W, with all-ones wrap detection.
// Purely combinational, no handshake.
module sc_pc_next
   import sc_pc_sequencer_pkg::*;
#(
   parameter int W = PCSEQ_DEFAULT_W
) (
   input  logic [W-1:0] pc,
   input  logic         branch_valid,
   input  logic [W-1:0] branch_target,
   output logic [W-1:0] pc_next,
   output logic         wrap
);

   logic [W-1:0] pc_inc;

   assign pc_inc  = pc + W'(1);
   assign pc_next = branch_valid ? branch_target : pc_inc;
   // A taken branch replaces the increment, so it also suppresses the wrap pulse.
   assign wrap    = ~branch_valid & (&pc);

endmodule

// File: rtl/sc_pc_sequencer.sv
// PC sequencer: owns the PC, issues fetch req/ack, advances by +1 or branch, halt/resume, fetch timeout.
// All outputs registered; fetch-to-fetch spacing is 2 cycles minimum, a stalled ack holds FETCH up to MAX_WAIT cycles.
module sc_pc_sequencer
   import sc_pc_sequencer_pkg::*;
#(
   parameter int          DATAWIDTH_BUS_PCSEQ = PCSEQ_DEFAULT_W,
   parameter int unsigned RESET_VECTOR        = 0,
   parameter int unsigned MAX_WAIT            = 15
) (
   input logic              SC_PCSEQ_CLOCK_50,
   input logic              SC_PCSEQ_RESET_InHigh,
   sc_pc_sequencer_if.slave bus
);

   localparam int W  = DATAWIDTH_BUS_PCSEQ;
   localparam int CW = $clog2(MAX_WAIT + 1);

   pcseq_state_t state, state_nxt;
   logic [W-1:0]  pc, pc_nxt;
   logic [CW-1:0] wait_cnt, wait_cnt_nxt;
   logic          wrap_nxt;
   logic          req_q, running_q, wrap_q, error_q;
   logic [W-1:0]  adv_pc;
   logic          adv_wrap;

   sc_pc_next #(.W(W)) u_next (
      .pc            (pc),
      .branch_valid  (bus.PCSEQ_BRANCH_VALID),
      .branch_target (bus.PCSEQ_BRANCH_TARGET),
      .pc_next       (adv_pc),
      .wrap          (adv_wrap)
   );

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      wait_cnt_nxt = wait_cnt;
      wrap_nxt     = 1'b0;
      case (state)
         ST_IDLE, ST_HALT: begin
            if (bus.PCSEQ_START && !bus.PCSEQ_HALT) begin
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            // HALT is deliberately not looked at here; it only takes effect after the fetch retires.
            if (bus.PCSEQ_FETCH_ACK) begin
               state_nxt    = ST_ADVANCE;
               wait_cnt_nxt = '0;
            end else begin
               wait_cnt_nxt = wait_cnt + CW'(1);
               if (wait_cnt_nxt == CW'(MAX_WAIT)) begin
                  state_nxt = ST_ERROR;
               end
            end
         end
         ST_ADVANCE: begin
            pc_nxt    = adv_pc;
            wrap_nxt  = adv_wrap;
            state_nxt = bus.PCSEQ_HALT ? ST_HALT : ST_FETCH;
         end
         ST_ERROR: begin
            state_nxt = ST_ERROR;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Status flags are loaded from the next state so they line up with the state register.
   always_ff @(posedge SC_PCSEQ_CLOCK_50) begin
      if (SC_PCSEQ_RESET_InHigh) begin
         state     <= ST_IDLE;
         pc        <= W'(RESET_VECTOR);
         wait_cnt  <= '0;
         req_q     <= 1'b0;
         running_q <= 1'b0;
         wrap_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         wait_cnt  <= wait_cnt_nxt;
         req_q     <= (state_nxt == ST_FETCH);
         running_q <= is_running(state_nxt);
         wrap_q    <= wrap_nxt;
         error_q   <= (state_nxt == ST_ERROR);
      end
   end

   assign bus.PCSEQ_PC_OUTPUT = pc;
   assign bus.PCSEQ_FETCH_REQ = req_q;
   assign bus.PCSEQ_RUNNING   = running_q;
   assign bus.PCSEQ_WRAP      = wrap_q;
   assign bus.PCSEQ_ERROR     = error_q;

endmodule

// File: tb/tb_sc_pc_sequencer.sv
// Scoreboard bench: transaction tasks push per-cycle expected outputs, a negedge monitor pops and compares.
module tb_sc_pc_sequencer;

   localparam int W    = 11;
   localparam int MW   = 15;
   localparam int RV   = 0;
   localparam int MASK = (1 << W) - 1;

   typedef struct {
      int           cyc;
      logic [W-1:0] pc;
      bit           req;
      bit           run;
      bit           wrap;
      bit           err;
      string        tag;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sc_pc_sequencer_if #(.W(W)) bus ();

   sc_pc_sequencer #(
      .DATAWIDTH_BUS_PCSEQ (W),
      .RESET_VECTOR        (RV),
      .MAX_WAIT            (MW)
   ) dut (
      .SC_PCSEQ_CLOCK_50     (clk),
      .SC_PCSEQ_RESET_InHigh (rst),
      .bus                   (bus)
   );

   // Monitor: compares every expectation due at the current cycle.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         total++;
         if (e.cyc != cyc || bus.PCSEQ_PC_OUTPUT !== e.pc || bus.PCSEQ_FETCH_REQ !== e.req ||
             bus.PCSEQ_RUNNING !== e.run || bus.PCSEQ_WRAP !== e.wrap || bus.PCSEQ_ERROR !== e.err) begin
            bad++;
            $display("FAIL %s cyc=%0d due=%0d got pc=%h req=%b run=%b wrap=%b err=%b want pc=%h req=%b run=%b wrap=%b err=%b",
                     e.tag, cyc, e.cyc, bus.PCSEQ_PC_OUTPUT, bus.PCSEQ_FETCH_REQ, bus.PCSEQ_RUNNING,
                     bus.PCSEQ_WRAP, bus.PCSEQ_ERROR, e.pc, e.req, e.run, e.wrap, e.err);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [W-1:0] pc_m;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] pc, input bit req, input bit run,
                       input bit wrap, input bit err, input string tag);
      exp_t e;
      e.cyc = cyc + 1;
      e.pc = pc; e.req = req; e.run = run; e.wrap = wrap; e.err = err; e.tag = tag;
      sb.push_back(e);
   endtask

   function automatic bit rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [W-1:0] rpc();
      case ($urandom_range(0, 3))
         0:       return W'(MASK);
         1:       return W'(MASK - 1);
         default: return W'($urandom_range(0, MASK));
      endcase
   endfunction

   task automatic set_in(input bit start, input bit halt, input bit ack,
                         input bit bv, input logic [W-1:0] tgt);
      bus.PCSEQ_START         = start;
      bus.PCSEQ_HALT          = halt;
      bus.PCSEQ_FETCH_ACK     = ack;
      bus.PCSEQ_BRANCH_VALID  = bv;
      bus.PCSEQ_BRANCH_TARGET = tgt;
   endtask

   task automatic t_reset(input string tag);
      set_in(rbit(), rbit(), rbit(), rbit(), rpc());
      rst = 1'b1;
      push(W'(RV), 0, 0, 0, 0, tag);
      tick();
      rst = 1'b0;
      pc_m = W'(RV);
   endtask

   // Idle/halted cycles: START is only ever offered together with HALT, so nothing moves.
   task automatic t_idle(input int n);
      for (int i = 0; i < n; i++) begin
         set_in(rbit(), 1'b1, rbit(), rbit(), rpc());
         push(pc_m, 0, 0, 0, 0, "idle_hold");
         tick();
      end
   endtask

   task automatic t_start();
      set_in(1'b1, 1'b0, rbit(), rbit(), rpc());
      push(pc_m, 1, 1, 0, 0, "start");
      tick();
   endtask

   // Called in the first FETCH cycle; ack arrives in FETCH cycle d, then the ADVANCE cycle.
   task automatic t_fetch(input int d, input bit br, input logic [W-1:0] tgt,
                          input bit h, input bit h_in_fetch);
      logic [W-1:0] nxt;
      bit           wr;
      for (int i = 1; i <= d; i++) begin
         set_in(rbit(), h_in_fetch, (i == d), rbit(), rpc());
         if (i < d) push(pc_m, 1, 1, 0, 0, "fetch_wait");
         else       push(pc_m, 0, 1, 0, 0, "advance");
         tick();
      end
      set_in(rbit(), h, rbit(), br, tgt);
      nxt = br ? tgt : W'((int'(pc_m) + 1) % (MASK + 1));
      wr  = !br && (int'(pc_m) == MASK);
      push(nxt, !h, !h, wr, 0, h ? "halt_entry" : "next_fetch");
      tick();
      pc_m = nxt;
   endtask

   task automatic t_timeout();
      for (int i = 1; i <= MW; i++) begin
         set_in(rbit(), rbit(), 1'b0, rbit(), rpc());
         if (i < MW) push(pc_m, 1, 1, 0, 0, "timeout_wait");
         else        push(pc_m, 0, 0, 0, 1, "timeout_error");
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 1'b0, 1'b1, rbit(), rpc());
         push(pc_m, 0, 0, 0, 1, "error_sticky");
         tick();
      end
   endtask

   task automatic t_abort(input int k);
      for (int i = 0; i < k; i++) begin
         set_in(rbit(), rbit(), 1'b0, rbit(), rpc());
         push(pc_m, 1, 1, 0, 0, "abort_wait");
         tick();
      end
      t_reset("reset_mid_fetch");
   endtask

   int mode;
   int r;
   bit h;
   bit br;

   initial begin
      set_in(0, 0, 0, 0, '0);
      t_reset("reset_state");
      t_idle(2);

      // Back-to-back fetches, ack in the first FETCH cycle.
      t_start();
      repeat (3) t_fetch(1, 0, '0, 0, 0);

      // Wrap through all-ones, then a branch in the wrap cycle.
      t_fetch(1, 1, W'(MASK - 1), 0, 0);
      t_fetch(1, 0, '0, 0, 0);
      t_fetch(1, 0, '0, 0, 0);
      t_fetch(2, 1, W'(MASK), 0, 0);
      t_fetch(1, 1, W'('h123), 0, 0);

      // Halt raised during a fetch: fetch retires, then resume at the held PC.
      t_fetch(3, 0, '0, 1, 1);
      t_idle(3);
      t_start();

      // Ack on the very last cycle before timeout.
      t_fetch(MW, 0, '0, 0, 0);

      t_timeout();
      t_reset("reset_clears_error");

      t_start();
      t_abort(0);
      t_start();
      t_abort(3);

      mode = 0;
      for (int n = 0; n < 300; n++) begin
         if (mode == 0) begin
            if ($urandom_range(0, 9) == 0) begin
               t_reset("rnd_reset");
            end else begin
               t_idle($urandom_range(0, 2));
               t_start();
               mode = 1;
            end
         end else begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
               t_timeout();
               t_reset("rnd_reset_error");
               mode = 0;
            end else if (r == 1) begin
               t_abort($urandom_range(0, MW - 2));
               mode = 0;
            end else begin
               h  = ($urandom_range(0, 4) == 0);
               br = ($urandom_range(0, 2) == 0);
               t_fetch($urandom_range(1, MW), br, rpc(), h, rbit());
               mode = h ? 0 : 1;
            end
         end
      end

      repeat (3) tick();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
